i2c_target_responder: RTL and testbench



---
 rtl/i2c_target_responder_pkg.sv | 24 ++
 rtl/i2c_target_responder_line.sv | 54 +++++
 rtl/i2c_target_responder.sv | 202 ++++++++++++++++++++
 tb/tb_i2c_target_responder.sv | 285 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/i2c_target_responder_pkg.sv
// Shared definitions for the I2C target responder (PCF8574-style expander).
// Holds the one-hot state encoding, the default 7-bit target address,
// the default line-filter length and the ACK/NACK bit levels.
package i2c_target_responder_pkg;

   // One-hot state encoding; exported on the debug state port.
   typedef enum logic [7:0] {
      IDLE      = 8'b0000_0001,
      ADDR      = 8'b0000_0010,
      ADDR_ACK  = 8'b0000_0100,
      WR_DATA   = 8'b0000_1000,
      WR_ACK    = 8'b0001_0000,
      RD_DATA   = 8'b0010_0000,
      RD_ACK    = 8'b0100_0000,
      WAIT_STOP = 8'b1000_0000
   } state_t;

   localparam logic [6:0] DEFAULT_TARGET_ADDR = 7'h27;
   localparam int         DEFAULT_FILTER_LEN  = 4;

   localparam logic I2C_ACK  = 1'b0;
   localparam logic I2C_NACK = 1'b1;

endpackage

// File: rtl/i2c_target_responder_line.sv
// i2c_line_filter: conditions one asynchronous bus line.
// A 2-FF synchronizer feeds a stability filter; a new level is accepted
// only after FILTER_LEN consecutive equal synchronized samples, so the
// pin-to-level latency is 2+FILTER_LEN clks and shorter pulses vanish.
// Ports:
//   clk, reset_n : system clock, asynchronous active-low reset
//   line         : raw asynchronous bus line
//   level        : filtered line level (resets to the idle-high level)
//   rise, fall   : one-clk pulses in the cycle level changes
module i2c_line_filter #(
   parameter int FILTER_LEN = 4
) (
   input  logic clk,
   input  logic reset_n,
   input  logic line,
   output logic level,
   output logic rise,
   output logic fall
);

   localparam logic [3:0] LAST = 4'(FILTER_LEN - 1);

   logic       sync1;
   logic       sync2;
   logic [3:0] cnt;

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         sync1 <= 1'b1;
         sync2 <= 1'b1;
         level <= 1'b1;
         cnt   <= 4'd0;
         rise  <= 1'b0;
         fall  <= 1'b0;
      end else begin
         sync1 <= line;
         sync2 <= sync1;
         rise  <= 1'b0;
         fall  <= 1'b0;
         // cnt counts consecutive samples disagreeing with the accepted level
         if (sync2 == level) begin
            cnt <= 4'd0;
         end else if (cnt == LAST) begin
            level <= sync2;
            cnt   <= 4'd0;
            rise  <= sync2;
            fall  <= ~sync2;
         end else begin
            cnt <= cnt + 4'd1;
         end
      end
   end

endmodule

// File: rtl/i2c_target_responder.sv
// i2c_target_responder: I2C target emulating a PCF8574-style expander.
// Write transfers present each received byte on rx_data (rx_valid pulse);
// read transfers return tx_data, reloaded after every master ACK.
// SDA is open-drain: sda_oe=1 pulls the line low, 0 releases it.
// Ports:
//   clk, reset_n     : system clock, asynchronous active-low reset
//   scl, sda_in      : asynchronous bus lines
//   sda_oe           : registered SDA pull-down enable
//   tx_data          : byte returned on reads (sampled at load points only)
//   rx_data/rx_valid : last written byte and its one-clk update pulse
//   rd_done          : one-clk pulse when the master's ack bit is sampled
//   busy             : high from START to STOP
//   addr_match       : high from address ack until STOP / repeated START
//   state            : debug view of the FSM state
module i2c_target_responder
   import i2c_target_responder_pkg::*;
#(
   parameter logic [6:0] TARGET_ADDR = DEFAULT_TARGET_ADDR,
   parameter int         FILTER_LEN  = DEFAULT_FILTER_LEN
) (
   input  logic       clk,
   input  logic       reset_n,
   input  logic       scl,
   input  logic       sda_in,
   output logic       sda_oe,
   input  logic [7:0] tx_data,
   output logic [7:0] rx_data,
   output logic       rx_valid,
   output logic       rd_done,
   output logic       busy,
   output logic       addr_match,
   output state_t     state
);

   logic scl_level, scl_rise, scl_fall;
   logic sda_level, sda_rise, sda_fall;

   i2c_line_filter #(.FILTER_LEN(FILTER_LEN)) u_scl_filter (
      .clk(clk), .reset_n(reset_n), .line(scl),
      .level(scl_level), .rise(scl_rise), .fall(scl_fall)
   );

   i2c_line_filter #(.FILTER_LEN(FILTER_LEN)) u_sda_filter (
      .clk(clk), .reset_n(reset_n), .line(sda_in),
      .level(sda_level), .rise(sda_rise), .fall(sda_fall)
   );

   logic start_cond, stop_cond;
   assign start_cond = sda_fall & scl_level;
   assign stop_cond  = sda_rise & scl_level;

   state_t     state_n;
   logic [2:0] bit_cnt, bit_cnt_n;
   logic [7:0] shift, shift_n;
   logic       byte_done, byte_done_n;  // 8th rising edge of a byte seen
   logic       rw, rw_n;                // R/W bit of the matched address
   logic       mack, mack_n;            // master's ack bit on reads
   logic       sda_oe_n, rx_valid_n, rd_done_n, busy_n, addr_match_n;
   logic [7:0] rx_data_n;

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state      <= IDLE;
         bit_cnt    <= 3'd0;
         shift      <= 8'd0;
         byte_done  <= 1'b0;
         rw         <= 1'b0;
         mack       <= I2C_NACK;
         sda_oe     <= 1'b0;
         rx_data    <= 8'd0;
         rx_valid   <= 1'b0;
         rd_done    <= 1'b0;
         busy       <= 1'b0;
         addr_match <= 1'b0;
      end else begin
         state      <= state_n;
         bit_cnt    <= bit_cnt_n;
         shift      <= shift_n;
         byte_done  <= byte_done_n;
         rw         <= rw_n;
         mack       <= mack_n;
         sda_oe     <= sda_oe_n;
         rx_data    <= rx_data_n;
         rx_valid   <= rx_valid_n;
         rd_done    <= rd_done_n;
         busy       <= busy_n;
         addr_match <= addr_match_n;
      end
   end

   always_comb begin
      state_n      = state;
      bit_cnt_n    = bit_cnt;
      shift_n      = shift;
      byte_done_n  = byte_done;
      rw_n         = rw;
      mack_n       = mack;
      sda_oe_n     = sda_oe;
      rx_data_n    = rx_data;
      rx_valid_n   = 1'b0;
      rd_done_n    = 1'b0;
      busy_n       = busy;
      addr_match_n = addr_match;

      // START (including repeated START) and STOP override bit processing
      if (start_cond) begin
         state_n      = ADDR;
         bit_cnt_n    = 3'd0;
         byte_done_n  = 1'b0;
         sda_oe_n     = 1'b0;
         busy_n       = 1'b1;
         addr_match_n = 1'b0;
      end else if (stop_cond) begin
         state_n      = IDLE;
         byte_done_n  = 1'b0;
         sda_oe_n     = 1'b0;
         busy_n       = 1'b0;
         addr_match_n = 1'b0;
      end else begin
         unique case (state)
            ADDR, WR_DATA: begin
               if (scl_rise) begin
                  shift_n   = {shift[6:0], sda_level};
                  bit_cnt_n = bit_cnt + 3'd1;
                  if (bit_cnt == 3'd7) begin
                     byte_done_n = 1'b1;
                     if (state == WR_DATA) begin
                        rx_data_n  = {shift[6:0], sda_level};
                        rx_valid_n = 1'b1;
                     end
                  end
               end else if (scl_fall && byte_done) begin
                  byte_done_n = 1'b0;
                  if (state == WR_DATA) begin
                     sda_oe_n = 1'b1;
                     state_n  = WR_ACK;
                  end else if (shift[7:1] == TARGET_ADDR) begin
                     sda_oe_n     = 1'b1;
                     addr_match_n = 1'b1;
                     rw_n         = shift[0];
                     state_n      = ADDR_ACK;
                  end else begin
                     sda_oe_n = 1'b0;
                     state_n  = WAIT_STOP;
                  end
               end
            end
            ADDR_ACK: begin
               if (scl_fall) begin
                  bit_cnt_n = 3'd0;
                  if (rw) begin
                     shift_n  = tx_data;
                     sda_oe_n = ~tx_data[7];
                     state_n  = RD_DATA;
                  end else begin
                     sda_oe_n = 1'b0;
                     state_n  = WR_DATA;
                  end
               end
            end
            WR_ACK: begin
               if (scl_fall) begin
                  sda_oe_n  = 1'b0;
                  bit_cnt_n = 3'd0;
                  state_n   = WR_DATA;
               end
            end
            RD_DATA: begin
               // bit 7 is already on the line; each fall presents the next bit
               if (scl_fall) begin
                  if (bit_cnt == 3'd7) begin
                     sda_oe_n  = 1'b0;
                     bit_cnt_n = 3'd0;
                     state_n   = RD_ACK;
                  end else begin
                     shift_n   = {shift[6:0], 1'b0};
                     sda_oe_n  = ~shift[6];
                     bit_cnt_n = bit_cnt + 3'd1;
                  end
               end
            end
            RD_ACK: begin
               if (scl_rise) begin
                  mack_n    = sda_level;
                  rd_done_n = 1'b1;
               end else if (scl_fall) begin
                  if (mack == I2C_ACK) begin
                     shift_n  = tx_data;
                     sda_oe_n = ~tx_data[7];
                     state_n  = RD_DATA;
                  end else begin
                     sda_oe_n = 1'b0;
                     state_n  = WAIT_STOP;
                  end
               end
            end
            default: ;  // IDLE and WAIT_STOP only react to START/STOP
         endcase
      end
   end

endmodule

// File: tb/tb_i2c_target_responder.sv
// Bench for i2c_target_responder: a bit-level I2C master model drives
// scl/sda over a wired-AND bus; written bytes are checked through an
// expected queue popped on rx_valid, read bytes through a second queue
// popped when the master finishes each byte.
module tb_i2c_target_responder;
   import i2c_target_responder_pkg::*;

   logic       clk = 1'b0;
   logic       reset_n = 1'b0;
   logic       scl = 1'b1;
   logic       sda_m = 1'b1;
   logic [7:0] tx_data = 8'h00;
   logic       sda_oe;
   logic [7:0] rx_data;
   logic       rx_valid;
   logic       rd_done;
   logic       busy;
   logic       addr_match;
   state_t     state;
   logic       sda_line;

   assign sda_line = sda_m & ~sda_oe;

   i2c_target_responder #(.TARGET_ADDR(7'h27), .FILTER_LEN(4)) dut (
      .clk(clk), .reset_n(reset_n), .scl(scl), .sda_in(sda_line),
      .sda_oe(sda_oe), .tx_data(tx_data), .rx_data(rx_data),
      .rx_valid(rx_valid), .rd_done(rd_done), .busy(busy),
      .addr_match(addr_match), .state(state)
   );

   always #5 clk = ~clk;

   int         checks = 0;
   int         fails = 0;
   logic [7:0] exp_q[$];
   logic [7:0] rd_q[$];
   logic [7:0] mon_e;
   int         rx_cnt = 0;
   int         rd_cnt = 0;
   logic       oe_seen = 1'b0;
   logic       oe_prev = 1'b0;

   // Scoreboard monitor: pops expected written bytes on rx_valid and
   // checks that sda_oe only ever moves while SCL is low.
   always @(negedge clk) begin
      if (reset_n) begin
         if (rx_valid) begin
            rx_cnt++;
            checks++;
            if (exp_q.size() == 0) begin
               fails++;
               $display("FAIL rx_unexpected: rx_data=%h, expected queue empty", rx_data);
            end else begin
               mon_e = exp_q.pop_front();
               if (rx_data !== mon_e) begin
                  fails++;
                  $display("FAIL rx_data: got %h expected %h", rx_data, mon_e);
               end
            end
         end
         if (rd_done) rd_cnt++;
         if (sda_oe) oe_seen = 1'b1;
         if (sda_oe !== oe_prev) begin
            checks++;
            if (scl !== 1'b0) begin
               fails++;
               $display("FAIL sda_oe_while_scl_high: sda_oe=%b scl=%b expected scl=0", sda_oe, scl);
            end
         end
      end
      oe_prev = sda_oe;
   end

   initial begin
      #700000;
      $display("FAIL watchdog: simulation time limit reached");
      $display("End of test - %0d assertions evaluated, %0d failures", checks, fails + 1);
      $fatal(1, "watchdog");
   end

   task automatic wclk(input int n);
      repeat (n) @(negedge clk);
   endtask

   task automatic m_bit(input logic b, input int glitch, output logic s);
      wclk(10); sda_m = b;
      wclk(10); scl = 1'b1;
      wclk(3);  s = sda_line;
      wclk(3);
      if (glitch > 0) begin
         scl = 1'b0; wclk(glitch); scl = 1'b1;
      end
      wclk(14); scl = 1'b0;
   endtask

   task automatic m_start;
      if (scl == 1'b0) begin
         wclk(10); sda_m = 1'b1;
         wclk(10); scl = 1'b1;
         wclk(20);
      end
      sda_m = 1'b0; wclk(20);
      scl = 1'b0;
   endtask

   task automatic m_stop;
      wclk(10); sda_m = 1'b0;
      wclk(10); scl = 1'b1;
      wclk(20); sda_m = 1'b1;
      wclk(20);
   endtask

   task automatic m_write(input logic [7:0] b, output logic ack);
      logic s;
      for (int i = 7; i >= 0; i--) m_bit(b[i], 0, s);
      m_bit(1'b1, 0, ack);
   endtask

   task automatic m_read(input logic mack, output logic [7:0] b);
      logic s;
      for (int i = 7; i >= 0; i--) begin
         m_bit(1'b1, 0, s);
         b[i] = s;
      end
      m_bit(mack, 0, s);
   endtask

   task automatic test_reset;
      wclk(5);
      checks++; if (sda_oe !== 1'b0) begin fails++; $display("FAIL reset_sda_oe: got %b expected 0", sda_oe); end
      checks++; if (rx_data !== 8'h00) begin fails++; $display("FAIL reset_rx_data: got %h expected 00", rx_data); end
      checks++; if (rx_valid !== 1'b0 || rd_done !== 1'b0) begin fails++; $display("FAIL reset_pulses: rx_valid=%b rd_done=%b expected 0/0", rx_valid, rd_done); end
      checks++; if (busy !== 1'b0 || addr_match !== 1'b0) begin fails++; $display("FAIL reset_flags: busy=%b addr_match=%b expected 0/0", busy, addr_match); end
      checks++; if (state !== IDLE) begin fails++; $display("FAIL reset_state: got %h expected %h", state, IDLE); end
      reset_n = 1'b1;
      wclk(20);
      checks++; if (busy !== 1'b0 || state !== IDLE) begin fails++; $display("FAIL idle_after_reset: busy=%b state=%h expected 0/%h", busy, state, IDLE); end
   endtask

   task automatic test_write;
      logic ack;
      rx_cnt = 0;
      exp_q.push_back(8'hA5);
      m_start;
      wclk(10);
      checks++; if (busy !== 1'b1) begin fails++; $display("FAIL wr_busy: got %b expected 1", busy); end
      m_write(8'h4E, ack);
      checks++; if (ack !== I2C_ACK) begin fails++; $display("FAIL wr_addr_ack: got %b expected 0", ack); end
      checks++; if (addr_match !== 1'b1) begin fails++; $display("FAIL wr_addr_match: got %b expected 1", addr_match); end
      m_write(8'hA5, ack);
      checks++; if (ack !== I2C_ACK) begin fails++; $display("FAIL wr_data_ack: got %b expected 0", ack); end
      m_stop;
      checks++; if (busy !== 1'b0 || addr_match !== 1'b0) begin fails++; $display("FAIL wr_after_stop: busy=%b addr_match=%b expected 0/0", busy, addr_match); end
      checks++; if (rx_data !== 8'hA5) begin fails++; $display("FAIL wr_rx_data: got %h expected a5", rx_data); end
      checks++; if (rx_cnt !== 1 || exp_q.size() !== 0) begin fails++; $display("FAIL wr_rx_count: pulses=%0d left=%0d expected 1/0", rx_cnt, exp_q.size()); end
   endtask

   task automatic test_mismatch;
      logic ack;
      rx_cnt = 0;
      oe_seen = 1'b0;
      m_start;
      m_write(8'h40, ack);
      checks++; if (ack !== I2C_NACK) begin fails++; $display("FAIL mm_addr_nack: got %b expected 1", ack); end
      checks++; if (state !== WAIT_STOP) begin fails++; $display("FAIL mm_state: got %h expected %h", state, WAIT_STOP); end
      m_write(8'h55, ack);
      checks++; if (ack !== I2C_NACK || addr_match !== 1'b0) begin fails++; $display("FAIL mm_data: ack=%b addr_match=%b expected 1/0", ack, addr_match); end
      m_stop;
      checks++; if (oe_seen !== 1'b0 || rx_cnt !== 0) begin fails++; $display("FAIL mm_quiet: oe_seen=%b rx_pulses=%0d expected 0/0", oe_seen, rx_cnt); end
      checks++; if (rx_data !== 8'hA5) begin fails++; $display("FAIL mm_rx_kept: got %h expected a5", rx_data); end
   endtask

   task automatic test_read;
      logic       ack;
      logic [7:0] b;
      logic [7:0] e;
      rd_cnt = 0;
      tx_data = 8'h3C;
      rd_q.push_back(8'h3C);
      m_start;
      m_write(8'h4F, ack);
      checks++; if (ack !== I2C_ACK) begin fails++; $display("FAIL rd_addr_ack: got %b expected 0", ack); end
      wclk(10);
      tx_data = 8'hC3;  // changes mid-byte, used only at the next reload
      rd_q.push_back(8'hC3);
      m_read(I2C_ACK, b);
      e = rd_q.pop_front();
      checks++; if (b !== e) begin fails++; $display("FAIL rd_byte0: got %h expected %h", b, e); end
      wclk(10);
      tx_data = 8'h00;
      m_read(I2C_NACK, b);
      e = rd_q.pop_front();
      checks++; if (b !== e) begin fails++; $display("FAIL rd_byte1: got %h expected %h", b, e); end
      wclk(12);
      checks++; if (sda_oe !== 1'b0 || state !== WAIT_STOP) begin fails++; $display("FAIL rd_after_nack: sda_oe=%b state=%h expected 0/%h", sda_oe, state, WAIT_STOP); end
      checks++; if (rd_cnt !== 2) begin fails++; $display("FAIL rd_done_count: got %0d expected 2", rd_cnt); end
      m_stop;
      checks++; if (busy !== 1'b0) begin fails++; $display("FAIL rd_busy_after_stop: got %b expected 0", busy); end
   endtask

   task automatic test_rstart;
      logic ack;
      logic s;
      rx_cnt = 0;
      exp_q.push_back(8'h81);
      m_start;
      m_write(8'h4E, ack);
      m_bit(1'b1, 0, s); m_bit(1'b1, 0, s); m_bit(1'b0, 0, s);
      m_start;
      wclk(5);
      checks++; if (state !== ADDR || addr_match !== 1'b0) begin fails++; $display("FAIL rs_state: state=%h addr_match=%b expected %h/0", state, addr_match, ADDR); end
      m_write(8'h4E, ack);
      checks++; if (ack !== I2C_ACK) begin fails++; $display("FAIL rs_addr_ack: got %b expected 0", ack); end
      m_write(8'h81, ack);
      m_stop;
      checks++; if (rx_data !== 8'h81 || rx_cnt !== 1) begin fails++; $display("FAIL rs_result: rx_data=%h pulses=%0d expected 81/1", rx_data, rx_cnt); end
   endtask

   task automatic test_glitch;
      logic       ack;
      logic       s;
      logic [7:0] b;
      logic [6:0] pat;
      rx_cnt = 0;
      b = 8'h5A;
      pat = 7'b1011001;
      exp_q.push_back(8'h5A);
      exp_q.push_back(8'hB3);  // last sent bit sampled twice by the 5-clk pulse
      m_start;
      m_write(8'h4E, ack);
      for (int i = 7; i >= 0; i--) m_bit(b[i], (i == 4) ? 2 : 0, s);
      m_bit(1'b1, 0, ack);
      checks++; if (ack !== I2C_ACK || rx_data !== 8'h5A) begin fails++; $display("FAIL gl_short: ack=%b rx_data=%h expected 0/5a", ack, rx_data); end
      for (int i = 6; i >= 0; i--) m_bit(pat[i], (i == 0) ? 5 : 0, s);
      m_bit(1'b1, 0, ack);
      checks++; if (ack !== I2C_ACK || rx_data !== 8'hB3) begin fails++; $display("FAIL gl_long: ack=%b rx_data=%h expected 0/b3", ack, rx_data); end
      m_stop;
      checks++; if (rx_cnt !== 2) begin fails++; $display("FAIL gl_count: got %0d expected 2", rx_cnt); end
   endtask

   task automatic test_reset_mid;
      logic ack;
      logic s;
      logic [7:0] a;
      a = 8'h4E;
      m_start;
      for (int i = 7; i >= 0; i--) m_bit(a[i], 0, s);
      wclk(12);
      checks++; if (state !== ADDR_ACK || sda_oe !== 1'b1) begin fails++; $display("FAIL rm_pre: state=%h sda_oe=%b expected %h/1", state, sda_oe, ADDR_ACK); end
      reset_n = 1'b0;
      #1;
      checks++; if (sda_oe !== 1'b0 || addr_match !== 1'b0 || busy !== 1'b0) begin fails++; $display("FAIL rm_release: sda_oe=%b addr_match=%b busy=%b expected 0/0/0", sda_oe, addr_match, busy); end
      checks++; if (rx_data !== 8'h00 || state !== IDLE) begin fails++; $display("FAIL rm_values: rx_data=%h state=%h expected 00/%h", rx_data, state, IDLE); end
      sda_m = 1'b1;
      wclk(2); scl = 1'b1;
      wclk(5); reset_n = 1'b1;
      wclk(20);
      rx_cnt = 0;
      exp_q.push_back(8'h12);
      m_start;
      m_write(8'h4E, ack);
      checks++; if (ack !== I2C_ACK) begin fails++; $display("FAIL rm_addr_ack: got %b expected 0", ack); end
      m_write(8'h12, ack);
      m_stop;
      checks++; if (ack !== I2C_ACK || rx_data !== 8'h12 || rx_cnt !== 1) begin fails++; $display("FAIL rm_write: ack=%b rx_data=%h pulses=%0d expected 0/12/1", ack, rx_data, rx_cnt); end
   endtask

   initial begin
      test_reset;
      test_write;
      test_mismatch;
      test_read;
      test_rstart;
      test_glitch;
      test_reset_mid;
      checks++;
      if (exp_q.size() !== 0) begin
         fails++;
         $display("FAIL scoreboard_drain: %0d bytes left expected 0", exp_q.size());
      end
      $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
      $finish;
   end

endmodule
